// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler driving a shared 8x1 mux, with a registered valid/ready output stage.
// Optional burst grants (up to BURST_MAX per winner) when MUX_ARB_BURST_EN is defined.
module mux8_rr_scheduler #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned N_REQ     = 8
`ifdef MUX_ARB_BURST_EN
    ,
    parameter int unsigned BURST_MAX = 4
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_W-1:0]     data_in,
    output logic [N_REQ-1:0]            ack,
    output logic [$clog2(N_REQ)-1:0]    select,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    input  logic                        out_ready
);

    localparam int unsigned SEL_W = $clog2(N_REQ);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_n;
    logic [SEL_W-1:0]   last_grant;
    logic [SEL_W-1:0]   winner;
    logic [SEL_W-1:0]   cand;
    logic               found;
    logic               capture;

`ifdef MUX_ARB_BURST_EN
    localparam int unsigned CNT_W = 2;
    // Grants so far to last_grant in the current burst; 0 means no burst in progress.
    logic [CNT_W-1:0]   burst_cnt;
    logic               keep;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Winner selection, capture qualification, ack and next state.
    always_comb begin
        winner  = last_grant;
        found   = 1'b0;
        cand    = '0;
        capture = 1'b0;
        ack     = '0;
        state_n = state;

        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = SEL_W'((int'(last_grant) + k) % int'(N_REQ));
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end

`ifdef MUX_ARB_BURST_EN
        keep = (burst_cnt != '0) && req[last_grant];
        if (keep) winner = last_grant;
`endif

        capture = !reset && (|req) && (state == IDLE || out_ready);
        if (capture) ack = N_REQ'(1) << winner;

        case (state)
            IDLE: if (|req) state_n = BUSY;
            BUSY: if (out_ready) state_n = (|req) ? BUSY : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output stage and rotation pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            select     <= '0;
            last_grant <= '1;
`ifdef MUX_ARB_BURST_EN
            burst_cnt  <= '0;
`endif
        end else begin
            out_valid <= (state_n == BUSY);
            if (capture) begin
                out_data   <= data_in[winner*DATA_W +: DATA_W];
                select     <= winner;
                last_grant <= winner;
`ifdef MUX_ARB_BURST_EN
                if (!keep)
                    burst_cnt <= CNT_W'(1);
                else if (32'(burst_cnt) + 32'd1 >= BURST_MAX)
                    burst_cnt <= '0;
                else
                    burst_cnt <= burst_cnt + CNT_W'(1);
`endif
            end
        end
    end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Self-checking bench for mux8_rr_scheduler: directed scenarios plus random traffic
// against a scan-based round-robin reference model (burst rules under MUX_ARB_BURST_EN).
module tb_mux8_rr_scheduler;

    localparam int unsigned DW = 64;
    localparam int unsigned NR = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] data_in;
    logic [NR-1:0]    ack;
    logic [2:0]       select;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_ready;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_last;
    int          m_sel;
    int          m_cnt;
    bit          m_valid;
    logic [63:0] m_data;
    bit          fix4 = 1'b0;

    always #5 clk = ~clk;

    mux8_rr_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data_in   (data_in),
        .ack       (ack),
        .select    (select),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = 7;
        m_sel   = 0;
        m_cnt   = 0;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    function automatic bit burst_keep(input logic [7:0] r);
`ifdef MUX_ARB_BURST_EN
        return (m_cnt != 0) && (m_cnt < 4) && r[m_last];
`else
        return 1'b0;
`endif
    endfunction

    function automatic int pick(input logic [7:0] r);
        if (burst_keep(r)) return m_last;
        for (int k = 1; k <= 8; k++)
            if (r[(m_last + k) % 8]) return (m_last + k) % 8;
        return 0;
    endfunction

    // One clock: drive inputs at negedge, check ack, then check registered outputs after posedge.
    task automatic step(input logic [7:0] r, input logic rdy, input string tag);
        int         g;
        bit         cap;
        bit         kp;
        logic [7:0] eack;
        @(negedge clk);
        reset     = 1'b0;
        req       = r;
        out_ready = rdy;
        for (int i = 0; i < 8; i++) data_in[i*64 +: 64] = {$urandom, $urandom};
        if (fix4) data_in[4*64 +: 64] = 64'hDEAD_BEEF_0000_0004;
        #1;
        cap  = (!m_valid || rdy) && (r != 8'h00);
        g    = cap ? pick(r) : 0;
        eack = cap ? 8'(1 << g) : 8'h00;
        check({tag, " ack"}, 64'(ack), 64'(eack));
        if (cap) begin
            kp     = burst_keep(r);
            m_cnt  = kp ? m_cnt + 1 : 1;
            m_last = g;
            m_sel  = g;
            m_data = data_in[g*64 +: 64];
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, 64'(out_valid), 64'(m_valid));
        check({tag, " select"},    64'(select),    64'(m_sel));
        check({tag, " out_data"},  out_data,       m_data);
    endtask

    // Hold reset across one rising edge with the given req pattern.
    task automatic do_reset(input logic [7:0] r);
        @(negedge clk);
        reset     = 1'b1;
        req       = r;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst ack",       64'(ack),       64'd0);
        check("rst select",    64'(select),    64'd0);
        check("rst out_data",  out_data,       64'd0);
    endtask

`ifdef MUX_ARB_BURST_EN
    int bseq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`endif

    initial begin
        reset     = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        data_in   = '0;
        model_reset();

        // Reset with all requesters pending; requester 0 wins first.
        do_reset(8'hFF);
        step(8'hFF, 1'b1, "first");
        check("first select", 64'(select), 64'd0);

        // Full rotation with all requesters pending.
        do_reset(8'hFF);
        for (int k = 0; k < 10; k++) begin
            step(8'hFF, 1'b1, "rot");
`ifndef MUX_ARB_BURST_EN
            check("rot order", 64'(select), 64'(k % 8));
`endif
        end

        // Single requester held while consumer stalls.
        do_reset(8'h00);
        fix4 = 1'b1;
        for (int k = 0; k < 3; k++) step(8'h10, 1'b0, "stall");
        check("stall data", out_data, 64'hDEAD_BEEF_0000_0004);
        fix4 = 1'b0;

        // Back-to-back transfers without a bubble.
        step(8'h06, 1'b1, "b2b");
        check("b2b valid", 64'(out_valid), 64'd1);
        step(8'h06, 1'b1, "b2b");
        check("b2b valid", 64'(out_valid), 64'd1);

        // Asynchronous reset while a word is held.
        step(8'h06, 1'b0, "hold");
        reset = 1'b1;
        #1;
        check("async rst valid", 64'(out_valid), 64'd0);
        model_reset();
        step(8'h80, 1'b1, "after rst");
        check("after rst select", 64'(select), 64'd7);

        // Random traffic against the model.
        for (int k = 0; k < 300; k++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = 8'h00;
            step(r, 1'($urandom_range(0, 1)), "rand");
        end

`ifdef MUX_ARB_BURST_EN
        do_reset(8'h00);
        for (int k = 0; k < 9; k++) begin
            step(8'h03, 1'b1, "burst");
            check("burst order", 64'(select), 64'(bseq[k]));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
